// File: rtl/pc_next_unit.sv
// Program counter register and next-PC selection: branch/jump/jump-register
// targets, fetch hold under imem back-pressure, halt, misaligned-target trap.
`timescale 1ns/1ps
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] branch_off,
   input  logic [25:0] jump_idx,
   input  logic [31:0] jr_target,
   input  logic [1:0]  pc_src,
   input  logic        branch_cond,
   input  logic        halt,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        trap,
   output logic        halted,
   output logic [31:0] instret
);

   localparam int unsigned W = 32;

   typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;

   state_t         state, state_nxt;
   logic           commit_c;
   logic           misalign_c;
   logic [W-1:0]   br_tgt_c, j_tgt_c, sel_tgt_c;
   logic [W-1:0]   pc_nxt, pc_plus4_nxt, instret_nxt;
   logic           fetch_valid_nxt, trap_nxt, halted_nxt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     state_nxt = imem_ready ? (halt ? HALT : RUN) : WAIT;
         WAIT:    if (imem_ready) state_nxt = halt ? HALT : RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = BOOT;
      endcase
   end

   // Candidate targets; all arithmetic wraps modulo 2^32
   always_comb begin
      commit_c = ((state == RUN) || (state == WAIT)) && imem_ready;
      br_tgt_c = pc_plus4 + branch_off;
      j_tgt_c  = {pc_plus4[31:28], jump_idx, 2'b00};
      case (pc_src)
         2'b01:   sel_tgt_c = branch_cond ? br_tgt_c : pc_plus4;
         2'b10:   sel_tgt_c = j_tgt_c;
         2'b11:   sel_tgt_c = jr_target;
         default: sel_tgt_c = pc_plus4;
      endcase
      misalign_c = |sel_tgt_c[1:0];
   end

   // Output / datapath next values; a halting commit retires but keeps pc
   always_comb begin
      pc_nxt          = pc;
      pc_plus4_nxt    = pc_plus4;
      instret_nxt     = instret;
      trap_nxt        = 1'b0;
      fetch_valid_nxt = (state_nxt == RUN) || (state_nxt == WAIT);
      halted_nxt      = (state_nxt == HALT);
      if (commit_c) begin
         instret_nxt = instret + W'(1);
         if (!halt) begin
            pc_nxt       = misalign_c ? TRAP_PC : sel_tgt_c;
            pc_plus4_nxt = pc_nxt + W'(4);
            trap_nxt     = misalign_c;
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         pc_plus4    <= RESET_PC + W'(4);
         fetch_valid <= 1'b0;
         trap        <= 1'b0;
         halted      <= 1'b0;
         instret     <= '0;
      end else begin
         pc          <= pc_nxt;
         pc_plus4    <= pc_plus4_nxt;
         fetch_valid <= fetch_valid_nxt;
         trap        <= trap_nxt;
         halted      <= halted_nxt;
         instret     <= instret_nxt;
      end
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed steps push hand-computed
// post-edge expectations; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_pc_next_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] branch_off;
   logic [25:0] jump_idx;
   logic [31:0] jr_target;
   logic [1:0]  pc_src;
   logic        branch_cond;
   logic        halt;
   logic        imem_ready;
   logic [31:0] pc, pc_plus4, instret;
   logic        fetch_valid, trap, halted;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        trap;
      logic        fv;
      logic        halted;
      logic [31:0] instret;
   } exp_t;

   exp_t exp_q[$];

   pc_next_unit #(.RESET_PC(32'h0000_0000), .TRAP_PC(32'h0000_0080)) dut (
      .clk(clk), .rst_n(rst_n), .branch_off(branch_off), .jump_idx(jump_idx),
      .jr_target(jr_target), .pc_src(pc_src), .branch_cond(branch_cond),
      .halt(halt), .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_valid(fetch_valid), .trap(trap), .halted(halted), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h expected=%h", name, step_no, act, exp);
      end
   endtask

   // Monitor: compare outputs 2ns after each edge against the queued expectation
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc",          pc,                 e.pc);
         chk("pc_plus4",    pc_plus4,           e.pc + 32'd4);
         chk("trap",        32'(trap),          32'(e.trap));
         chk("fetch_valid", 32'(fetch_valid),   32'(e.fv));
         chk("halted",      32'(halted),        32'(e.halted));
         chk("instret",     instret,            e.instret);
      end
   end

   // One clock: drive inputs, queue the expected post-edge state, advance past monitor
   task automatic step(input logic [1:0] src, input logic cond, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] jr, input logic hlt,
                       input logic rdy, input logic [31:0] e_pc, input logic e_trap,
                       input logic e_fv, input logic e_halt, input logic [31:0] e_ir);
      exp_t e;
      step_no++;
      pc_src = src; branch_cond = cond; branch_off = off; jump_idx = idx;
      jr_target = jr; halt = hlt; imem_ready = rdy;
      e = '{pc: e_pc, trap: e_trap, fv: e_fv, halted: e_halt, instret: e_ir};
      exp_q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic seq(input logic [31:0] e_pc, input logic [31:0] e_ir);
      step(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1, e_pc, 1'b0, 1'b1, 1'b0, e_ir);
   endtask

   task automatic jr_to(input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_trap,
                        input logic [31:0] e_ir);
      step(2'b11, 1'b0, 32'h0, 26'h0, tgt, 1'b0, 1'b1, e_pc, e_trap, 1'b1, 1'b0, e_ir);
   endtask

   task automatic check_reset_values();
      chk("rst_pc",          pc,               32'h0000_0000);
      chk("rst_pc_plus4",    pc_plus4,         32'h0000_0004);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_trap",        32'(trap),        32'd0);
      chk("rst_halted",      32'(halted),      32'd0);
      chk("rst_instret",     instret,          32'd0);
   endtask

   initial begin
      rst_n = 1'b0; pc_src = 2'b00; branch_cond = 1'b0; branch_off = '0;
      jump_idx = '0; jr_target = '0; halt = 1'b0; imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3 check_reset_values();
      rst_n = 1'b1;

      // BOOT cycle, then sequential fetch 4,8,12,16
      seq(32'h0, 32'd0);
      seq(32'h4, 32'd1);
      seq(32'h8, 32'd2);
      seq(32'hC, 32'd3);
      seq(32'h10, 32'd4);

      // Branch taken / not taken from pc=0x40
      jr_to(32'h40, 32'h40, 1'b0, 32'd5);
      step(2'b01, 1'b1, 32'hFFFF_FFF0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h34, 1'b0, 1'b1, 1'b0, 32'd6);
      jr_to(32'h40, 32'h40, 1'b0, 32'd7);
      step(2'b01, 1'b0, 32'hFFFF_FFF0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'd8);

      // J-type keeps pc_plus4[31:28]
      jr_to(32'h1000_0010, 32'h1000_0010, 1'b0, 32'd9);
      step(2'b10, 1'b0, 32'h0, 26'h0000123, 32'h0, 1'b0, 1'b1, 32'h1000_048C, 1'b0, 1'b1, 1'b0, 32'd10);

      // Misaligned jr traps for one cycle
      jr_to(32'h20, 32'h20, 1'b0, 32'd11);
      jr_to(32'h0000_0102, 32'h80, 1'b1, 32'd12);
      seq(32'h84, 32'd13);

      // Back-pressure: hold in WAIT for 3 cycles, then commit a branch
      jr_to(32'h8, 32'h8, 1'b0, 32'd14);
      for (int i = 0; i < 3; i++)
         step(2'b01, 1'b1, 32'h8, 26'h0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b0, 1'b1, 1'b0, 32'd14);
      step(2'b01, 1'b1, 32'h8, 26'h0, 32'h0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 32'd15);

      // Corrupt branch offset yields a misaligned br target
      step(2'b01, 1'b1, 32'h2, 26'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'd16);

      // Halt at 0x30 with a misaligned jr selected: no trap, pc kept, retires
      jr_to(32'h30, 32'h30, 1'b0, 32'd17);
      step(2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_0101, 1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'd18);
      step(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'd18);

      // Async reset out of HALT
      rst_n = 1'b0;
      #1 check_reset_values();
      @(posedge clk); #3 rst_n = 1'b1;

      // Reset in the middle of WAIT
      step(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);
      step(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);
      rst_n = 1'b0;
      #1 check_reset_values();

      // Bounded drain of the scoreboard
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
